// File: rtl/goertzel_multibin.sv
// Time-multiplexed fixed-point Goertzel: N_BINS bins updated one per cycle per sample, powers streamed per block.
// Latency: bin k updated at edge t+1+k after acceptance; power for bin k registered one cycle after it is processed.
// Backpressure: sample_ready low while busy; samples offered while not ready are dropped and flag sticky overrun.
module goertzel_multibin #(
    parameter int SAMPLE_W  = 16,
    parameter int COEFF_W   = 18,
    parameter int ACC_W     = 40,
    parameter int N_BINS    = 8,
    parameter int BLOCK_LEN = 205,
    parameter int POW_W     = 2*ACC_W+2,
    localparam int KW       = (N_BINS > 1) ? $clog2(N_BINS) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    input  logic                       coeff_wr_en,
    input  logic [KW-1:0]              coeff_wr_addr,
    input  logic signed [COEFF_W-1:0]  coeff_wr_data,
    output logic [POW_W-1:0]           power,
    output logic [KW-1:0]              power_bin,
    output logic                       power_valid,
    output logic                       block_done,
    output logic                       overrun
);
    localparam int NW = $clog2(BLOCK_LEN);
    localparam int MW = COEFF_W + ACC_W;        // full coeff*q1 product
    localparam int SW = MW + 2;                 // q0 sum before saturation
    localparam int PW = 2*ACC_W + COEFF_W + 4;  // power at full precision
    localparam logic [KW-1:0] K_LAST = KW'(N_BINS-1);
    localparam logic [NW-1:0] N_LAST = NW'(BLOCK_LEN-1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, POWER} state_t;

    state_t                      state_q, state_d;
    logic [KW-1:0]               k_q, k_d;
    logic [NW-1:0]               n_q, n_d;
    logic signed [SAMPLE_W-1:0]  x_q, x_d;
    logic signed [ACC_W-1:0]     q1_q [N_BINS];
    logic signed [ACC_W-1:0]     q1_d [N_BINS];
    logic signed [ACC_W-1:0]     q2_q [N_BINS];
    logic signed [ACC_W-1:0]     q2_d [N_BINS];
    logic signed [COEFF_W-1:0]   coeff_q [N_BINS];
    logic signed [COEFF_W-1:0]   coeff_d [N_BINS];
    logic [POW_W-1:0]            power_q, power_d;
    logic [KW-1:0]               power_bin_q, power_bin_d;
    logic                        power_valid_q, power_valid_d;
    logic                        block_done_q, block_done_d;
    logic                        overrun_q, overrun_d;

    logic signed [MW-1:0]        c_ext, q1_ext, prod, shifted;
    logic signed [SW-1:0]        q0_full;
    logic signed [ACC_W-1:0]     q0_sat;
    logic signed [PW-1:0]        q1_p, q2_p, sh_p, p_full;

    // Shared datapath for the bin selected by k: recurrence step and power term
    always_comb begin
        c_ext   = MW'(coeff_q[k_q]);
        q1_ext  = MW'(q1_q[k_q]);
        prod    = c_ext * q1_ext;
        shifted = prod >>> (COEFF_W-2);
        q0_full = SW'(x_q) + SW'(shifted) - SW'(q2_q[k_q]);
        if (q0_full > SW'(ACC_MAX)) begin
            q0_sat = ACC_MAX;
        end else if (q0_full < SW'(ACC_MIN)) begin
            q0_sat = ACC_MIN;
        end else begin
            q0_sat = q0_full[ACC_W-1:0];
        end
        q1_p   = PW'(q1_q[k_q]);
        q2_p   = PW'(q2_q[k_q]);
        sh_p   = PW'(shifted);
        p_full = q1_p*q1_p + q2_p*q2_p - sh_p*q2_p;
    end

    // Next-state: sample acceptance, per-bin accumulate, per-bin power readout
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        n_d           = n_q;
        x_d           = x_q;
        q1_d          = q1_q;
        q2_d          = q2_q;
        coeff_d       = coeff_q;
        power_d       = power_q;
        power_bin_d   = power_bin_q;
        power_valid_d = 1'b0;
        block_done_d  = 1'b0;
        overrun_d     = overrun_q;

        if (coeff_wr_en && (int'(coeff_wr_addr) < N_BINS)) begin
            coeff_d[coeff_wr_addr] = coeff_wr_data;
        end
        if (sample_valid && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    x_d     = sample;
                    k_d     = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                q2_d[k_q] = q1_q[k_q];
                q1_d[k_q] = q0_sat;
                if (k_q == K_LAST) begin
                    k_d = '0;
                    if (n_q == N_LAST) begin
                        n_d     = '0;
                        state_d = POWER;
                    end else begin
                        n_d     = n_q + NW'(1);
                        state_d = IDLE;
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            POWER: begin
                power_d       = (p_full < 0) ? '0 : p_full[POW_W-1:0];
                power_bin_d   = k_q;
                power_valid_d = 1'b1;
                block_done_d  = (k_q == K_LAST);
                q1_d[k_q]     = '0;
                q2_d[k_q]     = '0;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = IDLE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset that aborts any block in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            k_q           <= '0;
            n_q           <= '0;
            x_q           <= '0;
            power_q       <= '0;
            power_bin_q   <= '0;
            power_valid_q <= 1'b0;
            block_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
            for (int i = 0; i < N_BINS; i++) begin
                q1_q[i]    <= '0;
                q2_q[i]    <= '0;
                coeff_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            n_q           <= n_d;
            x_q           <= x_d;
            power_q       <= power_d;
            power_bin_q   <= power_bin_d;
            power_valid_q <= power_valid_d;
            block_done_q  <= block_done_d;
            overrun_q     <= overrun_d;
            q1_q          <= q1_d;
            q2_q          <= q2_d;
            coeff_q       <= coeff_d;
        end
    end

    assign sample_ready = (state_q == IDLE);
    assign power        = power_q;
    assign power_bin    = power_bin_q;
    assign power_valid  = power_valid_q;
    assign block_done   = block_done_q;
    assign overrun      = overrun_q;
endmodule

// File: tb/tb_goertzel_multibin.sv
// Scoreboard bench: a 128-bit reference model predicts each block's powers when samples are driven.
// Two instances: a 2-bin/4-sample engine and a 1-bin/8-sample 20-bit engine for saturation.
// Outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
module tb_goertzel_multibin;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // dut0: N_BINS=2, BLOCK_LEN=4, ACC_W=40
    logic signed [15:0] smp0;
    logic               sv0, rdy0, we0, pv0, bd0, ov0;
    logic [0:0]         wa0, pb0;
    logic signed [17:0] wd0;
    logic [81:0]        pw0;
    // dut1: N_BINS=1, BLOCK_LEN=8, ACC_W=20
    logic signed [15:0] smp1;
    logic               sv1, rdy1, we1, pv1, bd1, ov1;
    logic [0:0]         wa1, pb1;
    logic signed [17:0] wd1;
    logic [41:0]        pw1;

    goertzel_multibin #(.SAMPLE_W(16), .COEFF_W(18), .ACC_W(40), .N_BINS(2), .BLOCK_LEN(4), .POW_W(82)) dut0 (
        .clock(clock), .reset(reset), .sample(smp0), .sample_valid(sv0), .sample_ready(rdy0),
        .coeff_wr_en(we0), .coeff_wr_addr(wa0), .coeff_wr_data(wd0),
        .power(pw0), .power_bin(pb0), .power_valid(pv0), .block_done(bd0), .overrun(ov0));

    goertzel_multibin #(.SAMPLE_W(16), .COEFF_W(18), .ACC_W(20), .N_BINS(1), .BLOCK_LEN(8), .POW_W(42)) dut1 (
        .clock(clock), .reset(reset), .sample(smp1), .sample_valid(sv1), .sample_ready(rdy1),
        .coeff_wr_en(we1), .coeff_wr_addr(wa1), .coeff_wr_data(wd1),
        .power(pw1), .power_bin(pb1), .power_valid(pv1), .block_done(bd1), .overrun(ov1));

    typedef struct {
        logic [127:0] pw;
        int           bin;
        bit           done;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t e0, e1;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state, [dut][bin]
    logic signed [127:0] mq1 [2][2];
    logic signed [127:0] mq2 [2][2];
    logic signed [127:0] mc  [2][2];
    int                  mn  [2];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mn[d] = 0;
            for (int b = 0; b < 2; b++) begin
                mq1[d][b] = '0; mq2[d][b] = '0; mc[d][b] = '0;
            end
        end
    endtask

    task automatic model_sample(input int d, input logic signed [15:0] x);
        int nb, bl, accw, poww;
        logic signed [127:0] xs, q0, hi, lo, pr, p;
        exp_t e;
        nb   = (d == 0) ? 2 : 1;
        bl   = (d == 0) ? 4 : 8;
        accw = (d == 0) ? 40 : 20;
        poww = (d == 0) ? 82 : 42;
        xs   = x;
        hi   = (128'sd1 <<< (accw-1)) - 128'sd1;
        lo   = -hi - 128'sd1;
        for (int b = 0; b < nb; b++) begin
            q0 = xs + ((mc[d][b] * mq1[d][b]) >>> 16) - mq2[d][b];
            if (q0 > hi) q0 = hi;
            if (q0 < lo) q0 = lo;
            mq2[d][b] = mq1[d][b];
            mq1[d][b] = q0;
        end
        mn[d]++;
        if (mn[d] == bl) begin
            mn[d] = 0;
            for (int b = 0; b < nb; b++) begin
                pr = (mc[d][b] * mq1[d][b]) >>> 16;
                p  = mq1[d][b]*mq1[d][b] + mq2[d][b]*mq2[d][b] - pr*mq2[d][b];
                if (p < 0) p = '0;
                else       p = p & ((128'sd1 <<< poww) - 128'sd1);
                e.pw = p; e.bin = b; e.done = (b == nb-1);
                if (d == 0) sb0.push_back(e); else sb1.push_back(e);
                mq1[d][b] = '0; mq2[d][b] = '0;
            end
        end
    endtask

    task automatic wait_rdy(input int d);
        int i = 0;
        while (!((d == 0) ? rdy0 : rdy1) && i < 100) begin
            @(posedge clock); #1; i++;
        end
        if (i >= 100) check_eq("rdy_timeout", (d == 0) ? rdy0 : rdy1, 1);
    endtask

    // Offer one sample; with extra=1 the strobe is held one more cycle (dropped sample)
    task automatic send(input int d, input logic signed [15:0] x, input bit extra);
        wait_rdy(d);
        if (d == 0) begin sv0 = 1'b1; smp0 = x; end
        else        begin sv1 = 1'b1; smp1 = x; end
        model_sample(d, x);
        @(posedge clock); #1;
        if (extra) begin
            if (d == 0) smp0 = ~x; else smp1 = ~x;
            @(posedge clock); #1;
        end
        sv0 = 1'b0; sv1 = 1'b0;
    endtask

    task automatic cwr(input int d, input int addr, input logic signed [17:0] data);
        if (d == 0) begin we0 = 1'b1; wa0 = addr[0]; wd0 = data; end
        else        begin we1 = 1'b1; wa1 = addr[0]; wd1 = data; end
        if (addr < ((d == 0) ? 2 : 1)) mc[d][addr] = data;
        @(posedge clock); #1;
        we0 = 1'b0; we1 = 1'b0;
    endtask

    task automatic drain();
        int i = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && i < 100) begin
            @(posedge clock); #1; i++;
        end
        check_eq("drain", sb0.size() + sb1.size(), 0);
    endtask

    // Output monitors: every power_valid must match the head of its scoreboard
    always @(negedge clock) begin
        if (pv0 === 1'b1) begin
            if (sb0.size() == 0) check_eq("d0_unexpected_pv", pv0, 0);
            else begin
                e0 = sb0.pop_front();
                check_eq("d0_power", pw0, e0.pw);
                check_eq("d0_bin", pb0, e0.bin);
                check_eq("d0_done", bd0, e0.done);
            end
        end
        if (pv1 === 1'b1) begin
            if (sb1.size() == 0) check_eq("d1_unexpected_pv", pv1, 0);
            else begin
                e1 = sb1.pop_front();
                check_eq("d1_power", pw1, e1.pw);
                check_eq("d1_bin", pb1, e1.bin);
                check_eq("d1_done", bd1, e1.done);
            end
        end
    end

    initial begin
        int i;
        reset = 1'b1;
        smp0 = '0; sv0 = 1'b0; we0 = 1'b0; wa0 = '0; wd0 = '0;
        smp1 = '0; sv1 = 1'b0; we1 = 1'b0; wa1 = '0; wd1 = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        check_eq("rst_power", pw0, 0);
        check_eq("rst_pv", pv0, 0);
        check_eq("rst_done", bd0, 0);
        check_eq("rst_ovr", ov0, 0);
        check_eq("rst_rdy", rdy0, 1);
        check_eq("rst_pv1", pv1, 0);
        check_eq("rst_rdy1", rdy1, 1);

        // Saturation on the 20-bit engine; write to addr 1 is out of range and ignored
        cwr(1, 0, 18'sh1FFFF);
        cwr(1, 1, 18'sh20000);
        for (int s = 0; s < 8; s++) send(1, 16'sd32767, 1'b0);
        drain();
        check_eq("sat_ovr", ov1, 0);

        // Tone at fs/4 with all coefficients at reset value 0: both bins 4,000,000
        send(0, 16'sd1000, 1'b0);
        send(0, 16'sd0, 1'b0);
        send(0, -16'sd1000, 1'b0);
        send(0, 16'sd0, 1'b0);
        drain();

        // DC with zero coefficients: power 0 on both bins
        for (int s = 0; s < 4; s++) send(0, 16'sd1000, 1'b0);
        drain();

        // Coefficient change mid-block (1.0 in Q2.16) applies from the next sample
        send(0, 16'sd500, 1'b0);
        cwr(0, 1, 18'sh10000);
        send(0, 16'sd500, 1'b0);
        send(0, 16'sd200, 1'b0);
        send(0, -16'sd300, 1'b0);
        drain();

        // Overrun: strobe held one cycle past acceptance is dropped, flag sticks
        check_eq("ovr_clear", ov0, 0);
        send(0, 16'sd100, 1'b1);
        check_eq("ovr_set", ov0, 1);
        send(0, 16'sd200, 1'b0);
        send(0, 16'sd300, 1'b0);
        send(0, -16'sd400, 1'b0);
        check_eq("ovr_sticky", ov0, 1);
        drain();

        // Reset while bin0 power is valid: bin1 must never appear
        send(0, 16'sd1000, 1'b0);
        send(0, 16'sd0, 1'b0);
        send(0, -16'sd1000, 1'b0);
        send(0, 16'sd0, 1'b0);
        i = 0;
        while (pv0 !== 1'b1 && i < 50) begin
            @(posedge clock); #1; i++;
        end
        if (i >= 50) check_eq("pv_timeout", pv0, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        sb0.delete();
        sb1.delete();
        model_reset();
        repeat (10) @(posedge clock);
        #1;
        check_eq("mid_rst_ovr", ov0, 0);
        check_eq("mid_rst_rdy", rdy0, 1);
        check_eq("mid_rst_pv", pv0, 0);

        // Next block after the abort again yields 4,000,000
        send(0, 16'sd1000, 1'b0);
        send(0, 16'sd0, 1'b0);
        send(0, -16'sd1000, 1'b0);
        send(0, 16'sd0, 1'b0);
        drain();
        repeat (5) @(posedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
